// File: rtl/spi_frame_parser_pkg.sv
// rtl/spi_frame_parser_pkg.sv - command codes and FSM state encoding for spi_frame_parser
// Purpose: shared constants for the SPI command frame parser.
// Ports: none (package).
package spi_frame_parser_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WDATA   = 3'd3,
    ST_RDATA   = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

endpackage

// File: rtl/spi_frame_parser_sync.sv
// rtl/spi_frame_parser_sync.sv - two-flop synchroniser for one asynchronous bit
// Purpose: bring a single bit into the local clock domain.
// Ports:
//   i_clk  in  1  destination clock
//   i_rst  in  1  synchronous reset, active-high; both flops load RST_VAL
//   i_d    in  1  asynchronous input
//   o_q    out 1  synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_frame_parser.sv
// rtl/spi_frame_parser.sv - parses SPI command frames into an 8-bit register bank
// Purpose: synchronise byte strobes from spi_slave, decode CMD/ADDR/DATA frames,
//   write registers with burst auto-increment and return read data to spi_slave.
// Ports:
//   i_clk27m     in  1        system clock
//   i_rst        in  1        synchronous reset, active-high
//   i_rx_data    in  8        received byte, stable while i_data_valid high
//   i_data_valid in  1        byte-complete flag from SCLK domain
//   i_cs         in  1        raw chip select, active-low, asynchronous
//   o_tx_data    out 8        next byte for spi_slave to shift out
//   o_tx_start   out 1        one-cycle pulse, o_tx_data valid
//   o_wr_strobe  out 1        one-cycle pulse per register write
//   o_wr_addr    out AW       address of the write flagged by o_wr_strobe
//   o_reg_out    out 8*NREGS  register bank, reg k at [8k+7:8k]
//   o_frame_err  out 1        one-cycle pulse on unknown command byte
module spi_frame_parser
  import spi_frame_parser_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic               i_clk27m,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_data_valid,
  input  logic               i_cs,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_wr_strobe,
  output logic [AW-1:0]      o_wr_addr,
  output logic [8*NREGS-1:0] o_reg_out,
  output logic               o_frame_err
);

  logic          w_dv_s;
  logic          w_cs_s;
  logic          w_byte_evt;
  logic [AW-1:0] w_addr_in;
  logic [AW-1:0] w_ptr_inc;

  logic          r_dv_d;
  state_t        r_state;
  logic          r_mode_rd;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_regs [NREGS];
  logic [7:0]    r_tx_data;
  logic          r_tx_start;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;
  logic          r_frame_err;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_dv (
    .i_clk (i_clk27m),
    .i_rst (i_rst),
    .i_d   (i_data_valid),
    .o_q   (w_dv_s)
  );

  // cs resets deasserted so a reset always lands the FSM in IDLE.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
    .i_clk (i_clk27m),
    .i_rst (i_rst),
    .i_d   (i_cs),
    .o_q   (w_cs_s)
  );

  // The data bus is not synchronised: it has been stable for at least two
  // cycles by the time the synced strobe edge arrives, so it is sampled directly.
  assign w_byte_evt = w_dv_s & ~r_dv_d;
  assign w_addr_in  = i_rx_data[AW-1:0];
  assign w_ptr_inc  = r_ptr + AW'(1);

  always_ff @(posedge i_clk27m) begin
    if (i_rst) begin
      r_dv_d      <= 1'b0;
      r_state     <= ST_IDLE;
      r_mode_rd   <= 1'b0;
      r_ptr       <= '0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= 8'h00;
    end else begin
      r_dv_d      <= w_dv_s;
      r_tx_start  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_cs_s) r_state <= ST_CMD;
        end
        ST_CMD: begin
          if (w_byte_evt) begin
            if (i_rx_data == CMD_WRITE) begin
              r_mode_rd <= 1'b0;
              r_state   <= ST_ADDR;
            end else if (i_rx_data == CMD_READ) begin
              r_mode_rd <= 1'b1;
              r_state   <= ST_ADDR;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_DISCARD;
            end
          end
        end
        ST_ADDR: begin
          if (w_byte_evt) begin
            r_ptr <= w_addr_in;
            if (r_mode_rd) begin
              r_tx_data  <= r_regs[w_addr_in];
              r_tx_start <= 1'b1;
              r_state    <= ST_RDATA;
            end else begin
              r_state <= ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (w_byte_evt) begin
            r_regs[r_ptr] <= i_rx_data;
            r_wr_strobe   <= 1'b1;
            r_wr_addr     <= r_ptr;
            r_ptr         <= w_ptr_inc;
          end
        end
        ST_RDATA: begin
          // MOSI byte is a dummy; each one advances the read pointer.
          if (w_byte_evt) begin
            r_ptr      <= w_ptr_inc;
            r_tx_data  <= r_regs[w_ptr_inc];
            r_tx_start <= 1'b1;
          end
        end
        default: begin
          // ST_DISCARD: wait for cs to deassert.
        end
      endcase

      // Placed after the byte handling so a coincident byte is still processed.
      if (w_cs_s) begin
        r_state   <= ST_IDLE;
        r_ptr     <= '0;
        r_mode_rd <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NREGS; k++) begin : g_reg_out
    assign o_reg_out[8*k +: 8] = r_regs[k];
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_start  = r_tx_start;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_frame_parser.sv
// tb/tb_spi_frame_parser.sv - scoreboard testbench for spi_frame_parser
module tb_spi_frame_parser;

  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         rx_data = 8'h00;
  logic               data_valid = 1'b0;
  logic               cs = 1'b1;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               wr_strobe;
  logic [AW-1:0]      wr_addr;
  logic [8*NREGS-1:0] reg_out;
  logic               frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mregs [NREGS];
  logic [11:0] wq [$];
  logic [7:0]  rq [$];
  int          eq [$];

  always #18.5 clk = ~clk;

  spi_frame_parser #(.NREGS(NREGS), .AW(AW)) dut (
    .i_clk27m     (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_data_valid (data_valid),
    .i_cs         (cs),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_wr_strobe  (wr_strobe),
    .o_wr_addr    (wr_addr),
    .o_reg_out    (reg_out),
    .o_frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_bank();
    logic [127:0] v;
    for (int k = 0; k < NREGS; k++) v[8*k +: 8] = mregs[k];
    return v;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a pulse.
  logic prev_tx, prev_wr, prev_err;
  always @(negedge clk) begin
    if (rst) begin
      prev_tx = 1'b0; prev_wr = 1'b0; prev_err = 1'b0;
    end else begin
      if (wr_strobe) begin
        if (wq.size() == 0) begin
          check("unexpected_wr_strobe", 1, 0);
        end else begin
          logic [11:0] e;
          e = wq.pop_front();
          check("wr_addr", wr_addr, e[11:8]);
          check("wr_data_on_reg_out", reg_out[8*e[11:8] +: 8], e[7:0]);
        end
      end
      if (tx_start) begin
        if (rq.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          logic [7:0] r;
          r = rq.pop_front();
          check("tx_data", tx_data, r);
        end
      end
      if (frame_err) begin
        if (eq.size() == 0) check("unexpected_frame_err", 1, 0);
        else void'(eq.pop_front());
      end
      if ((tx_start && prev_tx) || (wr_strobe && prev_wr) || (frame_err && prev_err))
        check("pulse_two_cycles", 1, 0);
      prev_tx = tx_start; prev_wr = wr_strobe; prev_err = frame_err;
    end
  end

  // Reference model: whole-frame semantics computed from the byte list.
  task automatic model_frame(input logic [7:0] fr[$]);
    int ptr;
    if (fr.size() == 0) return;
    if (fr[0] == 8'h01) begin
      if (fr.size() >= 2) begin
        ptr = fr[1] % NREGS;
        for (int i = 2; i < fr.size(); i++) begin
          mregs[ptr] = fr[i];
          wq.push_back({4'(ptr), fr[i]});
          ptr = (ptr + 1) % NREGS;
        end
      end
    end else if (fr[0] == 8'h02) begin
      if (fr.size() >= 2) begin
        ptr = fr[1] % NREGS;
        rq.push_back(mregs[ptr]);
        for (int i = 2; i < fr.size(); i++) begin
          ptr = (ptr + 1) % NREGS;
          rq.push_back(mregs[ptr]);
        end
      end
    end else begin
      eq.push_back(1);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    data_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic open_frame();
    @(posedge clk); #1 cs = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic close_frame();
    @(posedge clk); #1 cs = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] fr[$]);
    model_frame(fr);
    open_frame();
    foreach (fr[i]) drive_byte(fr[i]);
    close_frame();
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(posedge clk);
    check({name, "_wq_empty"}, wq.size(), 0);
    check({name, "_rq_empty"}, rq.size(), 0);
    check({name, "_eq_empty"}, eq.size(), 0);
  endtask

  initial begin
    logic [127:0] snap;
    logic [7:0]   fr [$];
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_reg_out", reg_out, 128'h0);
    check("reset_outputs", {tx_data, tx_start, wr_strobe, wr_addr, frame_err}, 0);

    // T1: reset in the middle of a write frame.
    send_frame('{8'h01, 8'h07, 8'hAA});
    check("t1_pre_reg7", reg_out[8*7 +: 8], 8'hAA);
    open_frame();
    drive_byte(8'h01);
    drive_byte(8'h03);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t1_reg_out", reg_out, 128'h0);
    check("t1_outputs", {tx_data, tx_start, wr_strobe, wr_addr, frame_err}, 0);
    close_frame();
    for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;

    // T2: single write.
    send_frame('{8'h01, 8'h03, 8'hA5});
    check("t2_reg3", reg_out[8*3 +: 8], 8'hA5);
    drain_check("t2");

    // T3: burst write wrapping past the top register.
    send_frame('{8'h01, 8'h0F, 8'h11, 8'h22});
    check("t3_reg15", reg_out[8*15 +: 8], 8'h11);
    check("t3_reg0", reg_out[7:0], 8'h22);
    drain_check("t3");

    // T4: read back two preloaded registers.
    send_frame('{8'h01, 8'h02, 8'h5A, 8'hC3});
    send_frame('{8'h02, 8'h02, 8'h00, 8'h00});
    drain_check("t4");

    // T5: unknown command, then a good frame.
    snap = reg_out;
    send_frame('{8'h7E, 8'h01, 8'hFF});
    check("t5_regs_unchanged", reg_out, snap);
    send_frame('{8'h01, 8'h09, 8'h66});
    check("t5_recover_reg9", reg_out[8*9 +: 8], 8'h66);
    drain_check("t5");

    // T6: cs abort after CMD+ADDR.
    send_frame('{8'h01, 8'h04});
    send_frame('{8'h01, 8'h05, 8'h33});
    check("t6_reg5", reg_out[8*5 +: 8], 8'h33);
    check("t6_reg4", reg_out[8*4 +: 8], 8'h00);
    drain_check("t6");

    // Randomised frames, including high ADDR bits and foreign commands.
    for (int f = 0; f < 40; f++) begin
      int sel;
      int n;
      fr = {};
      sel = $urandom_range(0, 9);
      if (sel < 5)      fr.push_back(8'h01);
      else if (sel < 9) fr.push_back(8'h02);
      else              fr.push_back(8'(8'h03 + $urandom_range(0, 250)));
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
      send_frame(fr);
    end
    drain_check("random");
    check("final_bank", reg_out, model_bank());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
